regfile_mp_sb: RTL

- Parametrised multi-port general-purpose register file with an integrated pending-write scoreboard.
- Sits between decode/issue and writeback in the integer pipeline.
- Provides NRP combinational read ports and NWP synchronous write ports, with optional same-cycle write-to-read bypass.
- Tracks in-flight producers per register and reports a busy flag per read port for interlock/stall generation.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 31 +++
 rtl/regfile_mp_sb.sv | 78 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file and its pending-write scoreboard.
package rf_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  // Upper bounds on port counts, used when slicing the packed port buses.
  localparam int MAX_RP = 4;
  localparam int MAX_WP = 2;

  localparam logic [DW_DEF-1:0] ZERO_WORD = '0;
  localparam logic [AW_DEF-1:0] ZERO_REG  = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int NWP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NWP-1:0]    we,
  input  logic [NWP*AW-1:0] waddr,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_addr,
  output logic [2**AW-1:0]  pend
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend <= '0;
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (we[j]) pend[waddr[j*AW +: AW]] <= 1'b0;
      end
      // NOTE: the last non-blocking assignment to a bit in a cycle wins, so placing
      // the set after the clears makes a fresh issue override a same-cycle writeback.
      if (iss_v && iss_addr != AW'(ZERO_REG)) pend[iss_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with pending-write scoreboard (r0 hardwired to zero).
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRP = 2,
  parameter int NWP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRP-1:0]    re,
  input  logic [NRP*AW-1:0] raddr,
  output logic [NRP*DW-1:0] rdata,
  output logic [NRP-1:0]    rbusy,
  input  logic [NWP-1:0]    we,
  input  logic [NWP*AW-1:0] waddr,
  input  logic [NWP*DW-1:0] wdata,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic              any_busy
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] pend;

  rf_scoreboard #(.AW(AW), .NWP(NWP)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .we       (we),
    .waddr    (waddr),
    .iss_v    (iss_v),
    .iss_addr (iss_addr),
    .pend     (pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset entry by entry, which forces it into flops rather
      // than a RAM macro; reads right after reset must return zero.
      for (int i = 0; i < DEPTH; i++) regs[i] <= DW'(ZERO_WORD);
    end else begin
      // Ascending loop: a higher-index port to the same address lands last and wins.
      for (int j = 0; j < NWP; j++) begin
        if (we[j] && waddr[j*AW +: AW] != AW'(ZERO_REG))
          regs[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRP; k++) begin
      if (!rst && re[k] && raddr[k*AW +: AW] != AW'(ZERO_REG)) begin
        rdata[k*DW +: DW] = regs[raddr[k*AW +: AW]];
        rbusy[k]          = pend[raddr[k*AW +: AW]];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NWP; j++) begin
          if (we[j] && waddr[j*AW +: AW] == raddr[k*AW +: AW]) begin
            rdata[k*DW +: DW] = wdata[j*DW +: DW];
            rbusy[k]          = iss_v && !flush && (iss_addr == raddr[k*AW +: AW]);
          end
        end
`endif
      end
    end
  end

  assign any_busy = |(rbusy & re);

endmodule
